riscv_str_byte_seq: RTL and testbench
=====================================

RISCV_STR_BYTE_SEQ -- requirements
Module: riscv_str_byte_seq

Interface
REQ-001 SHALL have one clock and one reset: `clk` and `rst`; reset is synchronous and active-high.
REQ-002 SHALL take its operator encodings STR_OP_UPPER, STR_OP_LOWER, STR_OP_LEET and STR_OP_ROT13, and their width STR_OP_WIDTH, from riscv_defines; it has no module parameters.
REQ-003 SHALL have port `clk`  in  1  rising-edge clock.
REQ-004 SHALL have port `rst`  in  1  synchronous active-high reset.
REQ-005 SHALL have port `enable_i`  in  1  request strobe from the EX stage.
REQ-006 SHALL have port `operator_i`  in  STR_OP_WIDTH  string-op select.
REQ-007 SHALL have port `operand_i`  in  32  four packed ASCII bytes; byte0 = bits [7:0].
REQ-008 SHALL have port `flush_i`  in  1  abort of the in-flight op (pipeline kill).
REQ-009 SHALL have port `ex_ready_i`  in  1  EX stage consumes the result.
REQ-010 SHALL have port `result_o`  out  32  transformed word.
REQ-011 SHALL have port `valid_o`  out  1  result_o holds a completed result.
REQ-012 SHALL have port `ready_o`  out  1  unit is idle or finished; EX stage may advance.

Function
REQ-013 SHALL implement an FSM with exactly three states: IDLE, BUSY, DONE.
REQ-014 IDLE: ready_o=1, valid_o=0, result_o=0.
REQ-015 IDLE exits only when enable_i=1 and operator_i is one of the four defined codes: operand and operator are captured, byte counter is set to 0, and the next state is BUSY.
REQ-016 IDLE with enable_i=1 and an undefined operator_i SHALL stay IDLE; no capture, all outputs unchanged.
REQ-017 BUSY: ready_o=0, valid_o=0, result_o=0.
REQ-018 BUSY transforms one byte per cycle, byte index = counter (0,1,2,3 in order), and writes it into the same lane of the result register.
REQ-019 BUSY at counter 3 SHALL go to DONE; otherwise the counter increments by 1.
REQ-020 Latency: an accept at edge N gives valid_o=1 in the cycle after edge N+4 (4 BUSY cycles), independent of operator.
REQ-021 DONE: ready_o=1, valid_o=1, result_o = result register.
REQ-022 DONE holds result_o stable until ex_ready_i=1; on that edge the next state is IDLE.
REQ-023 enable_i is ignored in BUSY and DONE; back-to-back ops need one IDLE cycle between them.
REQ-024 flush_i=1 in BUSY or DONE SHALL force IDLE on the next edge and discard the result; flush_i has priority over ex_ready_i and counter completion; flush_i in IDLE has no effect and SHALL NOT block acceptance.
REQ-025 Byte rules for any other input byte: unchanged (no zeroing).
REQ-026 UPPER: bytes 0x61..0x7A map to byte-0x20.
REQ-027 LOWER: bytes 0x41..0x5A map to byte+0x20.
REQ-028 ROT13: within 0x41..0x5A and 0x61..0x7A, rotate by 13 modulo 26, case preserved; all arithmetic is 8-bit with no carry out.
REQ-029 LEET: case-insensitive a->0x34, e->0x33, i->0x31, o->0x30, s->0x35, t->0x37.
REQ-030 Transform inputs are the captured operand and operator only; changes on operand_i/operator_i after acceptance have no effect.
REQ-031 SHALL emit a $display of time, operator and operand on each accepted request (simulation only).

Reset
REQ-032 rst=1 at a rising edge SHALL set state IDLE, counter 0, operand, operator and result registers 0.
REQ-033 Outputs after reset: ready_o=1, valid_o=0, result_o=0.
REQ-034 rst has priority over flush_i, enable_i and ex_ready_i, and aborts a BUSY or DONE op with no valid_o pulse.

Verification
REQ-035 UPPER, operand 0x64636261 ("abcd"), ex_ready_i=1 -> ready_o low 4 cycles, then valid_o=1 with result_o=0x44434241 for one cycle, then IDLE.
REQ-036 LOWER, 0x5B40415A -> result_o=0x5B40617A; boundary bytes '@' (0x40) and '[' (0x5B) pass through unchanged.
REQ-037 ROT13, 0x7A4E2E61 -> result_o=0x6D412E6E (wrap z->m and N->A; '.' unchanged).
REQ-038 LEET, 0x74736561 -> result_o=0x37353334.
REQ-039 Completed op with ex_ready_i=0 for 3 cycles -> result_o, valid_o and ready_o held; enable_i pulses ignored; ex_ready_i=1 -> IDLE next cycle.
REQ-040 flush_i, and separately rst, asserted in BUSY at counter 2 -> IDLE next cycle with valid_o never asserted and result_o=0; a following UPPER 0x61616161 -> 0x41414141.

Source files
------------

// File: rtl/riscv_str_byte_seq.sv
// Byte-serial string transform unit: applies UPPER/LOWER/LEET/ROT13 to a packed
// 4-byte ASCII word, one byte per cycle, with a ready/valid handshake to EX.

package riscv_defines;
  localparam int STR_OP_WIDTH = 3;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
  localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;
endpackage

module riscv_str_byte_seq
  import riscv_defines::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [STR_OP_WIDTH-1:0] operator_i,
  input  logic [31:0]             operand_i,
  input  logic                    flush_i,
  input  logic                    ex_ready_i,
  output logic [31:0]             result_o,
  output logic                    valid_o,
  output logic                    ready_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_cnt;
  logic [31:0]             r_operand;
  logic [31:0]             r_result;
  logic [STR_OP_WIDTH-1:0] r_op;
  logic                    w_op_valid;
  logic                    w_accept;
  logic [7:0]              w_byte_in;
  logic [7:0]              w_byte_out;

  function automatic logic [7:0] f_upper(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
  endfunction

  function automatic logic [7:0] f_lower(input logic [7:0] b);
    return (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
  endfunction

  // Rotate by 13 within each case range: first half moves up, second half down.
  function automatic logic [7:0] f_rot13(input logic [7:0] b);
    if ((b >= 8'h41 && b <= 8'h4D) || (b >= 8'h61 && b <= 8'h6D)) return b + 8'd13;
    if ((b >= 8'h4E && b <= 8'h5A) || (b >= 8'h6E && b <= 8'h7A)) return b - 8'd13;
    return b;
  endfunction

  function automatic logic [7:0] f_leet(input logic [7:0] b);
    case (f_lower(b))
      8'h61:   return 8'h34;
      8'h65:   return 8'h33;
      8'h69:   return 8'h31;
      8'h6F:   return 8'h30;
      8'h73:   return 8'h35;
      8'h74:   return 8'h37;
      default: return b;
    endcase
  endfunction

  function automatic logic [7:0] f_xform(input logic [STR_OP_WIDTH-1:0] op,
                                         input logic [7:0] b);
    case (op)
      STR_OP_UPPER: return f_upper(b);
      STR_OP_LOWER: return f_lower(b);
      STR_OP_LEET:  return f_leet(b);
      STR_OP_ROT13: return f_rot13(b);
      default:      return b;
    endcase
  endfunction

  always_comb begin
    w_op_valid = 1'b0;
    case (operator_i)
      STR_OP_UPPER, STR_OP_LOWER, STR_OP_LEET, STR_OP_ROT13: w_op_valid = 1'b1;
      default: w_op_valid = 1'b0;
    endcase
  end

  assign w_accept   = (r_state == IDLE) && enable_i && w_op_valid;
  assign w_byte_in  = r_operand[{r_cnt, 3'b000} +: 8];
  assign w_byte_out = f_xform(r_op, w_byte_in);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = BUSY;
      BUSY: begin
        if (flush_i)              w_state_nxt = IDLE;
        else if (r_cnt == 2'd3)   w_state_nxt = DONE;
      end
      DONE: if (flush_i || ex_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_operand <= '0;
      r_op      <= '0;
      r_result  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_operand <= operand_i;
        r_op      <= operator_i;
        r_cnt     <= 2'd0;
        r_result  <= '0;
      end else if (r_state == BUSY && !flush_i) begin
        r_result[{r_cnt, 3'b000} +: 8] <= w_byte_out;
        r_cnt                          <= r_cnt + 2'd1;
      end
    end
  end

  assign ready_o  = (r_state != BUSY);
  assign valid_o  = (r_state == DONE);
  assign result_o = (r_state == DONE) ? r_result : 32'h0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_accept)
      $display("[%0t] str_byte_seq accept: op=%0d operand=%08h", $time, operator_i, operand_i);
  end
`endif

endmodule

// File: tb/tb_riscv_str_byte_seq.sv
// Bench for riscv_str_byte_seq: directed spec scenarios plus randomized traffic,
// every cycle compared against a behavioural transaction model.

module tb_riscv_str_byte_seq;
  import riscv_defines::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    enable_i = 1'b0;
  logic [STR_OP_WIDTH-1:0] operator_i = '0;
  logic [31:0]             operand_i = '0;
  logic                    flush_i = 1'b0;
  logic                    ex_ready_i = 1'b0;
  logic [31:0]             result_o;
  logic                    valid_o;
  logic                    ready_o;

  int checks = 0;
  int errors = 0;

  // Model: cycles of work left, whether a result is waiting, and that result.
  int          m_busy = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res  = '0;

  riscv_str_byte_seq dut (
    .clk        (clk),
    .rst        (rst),
    .enable_i   (enable_i),
    .operator_i (operator_i),
    .operand_i  (operand_i),
    .flush_i    (flush_i),
    .ex_ready_i (ex_ready_i),
    .result_o   (result_o),
    .valid_o    (valid_o),
    .ready_o    (ready_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] m_byte(input logic [STR_OP_WIDTH-1:0] op, input logic [7:0] b);
    int v;
    int lc;
    v = int'(b);
    if (op == STR_OP_UPPER) begin
      if (v >= 97 && v <= 122) v = v - 32;
    end else if (op == STR_OP_LOWER) begin
      if (v >= 65 && v <= 90) v = v + 32;
    end else if (op == STR_OP_ROT13) begin
      if (v >= 65 && v <= 90)       v = 65 + (v - 65 + 13) % 26;
      else if (v >= 97 && v <= 122) v = 97 + (v - 97 + 13) % 26;
    end else if (op == STR_OP_LEET) begin
      lc = (v >= 65 && v <= 90) ? v + 32 : v;
      case (lc)
        97:  v = 52;  // a -> '4'
        101: v = 51;  // e -> '3'
        105: v = 49;  // i -> '1'
        111: v = 48;  // o -> '0'
        115: v = 53;  // s -> '5'
        116: v = 55;  // t -> '7'
        default: ;
      endcase
    end
    return v[7:0];
  endfunction

  function automatic logic [31:0] m_word(input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m_byte(op, w[8*i +: 8]);
    return r;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_busy = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (flush_i || ex_ready_i) m_done = 1'b0;
    end else if (m_busy > 0) begin
      if (flush_i) m_busy = 0;
      else begin
        m_busy = m_busy - 1;
        if (m_busy == 0) m_done = 1'b1;
      end
    end else if (enable_i && operator_i < 4) begin
      m_res  = m_word(operator_i, operand_i);
      m_busy = 4;
    end
  endtask

  task automatic compare(input string name);
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_res;
    e_rdy = (m_busy == 0);
    e_vld = m_done;
    e_res = m_done ? m_res : 32'h0;
    checks++;
    if (ready_o !== e_rdy || valid_o !== e_vld || result_o !== e_res) begin
      errors++;
      $display("FAIL %s @%0t: got ready=%0b valid=%0b result=%08h, want ready=%0b valid=%0b result=%08h",
               name, $time, ready_o, valid_o, result_o, e_rdy, e_vld, e_res);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h, want %08h", name, got, want);
    end
  endtask

  task automatic step(input string name, input bit r, input bit en,
                      input logic [STR_OP_WIDTH-1:0] op, input logic [31:0] opd,
                      input bit fl, input bit exr);
    rst = r; enable_i = en; operator_i = op; operand_i = opd; flush_i = fl; ex_ready_i = exr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare(name);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] w;
    for (int i = 0; i < 4; i++)
      w[8*i +: 8] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(8'h40, 8'h7B)) : 8'($urandom);
    return w;
  endfunction

  initial begin
    // Model pins against hand-computed results.
    pin("pin_upper", m_word(STR_OP_UPPER, 32'h64636261), 32'h44434241);
    pin("pin_lower", m_word(STR_OP_LOWER, 32'h5B40415A), 32'h5B40617A);
    pin("pin_rot13", m_word(STR_OP_ROT13, 32'h7A4E2E61), 32'h6D412E6E);
    pin("pin_leet",  m_word(STR_OP_LEET,  32'h74736561), 32'h37353334);

    step("reset", 1, 0, STR_OP_UPPER, 32'h0, 0, 0);
    step("reset_hold", 1, 1, STR_OP_UPPER, 32'h61616161, 1, 1);

    // UPPER "abcd", consumed immediately
    step("upper_acc", 0, 1, STR_OP_UPPER, 32'h64636261, 0, 1);
    for (int i = 0; i < 6; i++) step("upper_run", 0, 0, STR_OP_UPPER, 32'hFFFFFFFF, 0, 1);

    // LOWER with boundary bytes; operand/operator change after acceptance
    step("lower_acc", 0, 1, STR_OP_LOWER, 32'h5B40415A, 0, 1);
    for (int i = 0; i < 6; i++) step("lower_run", 0, 0, STR_OP_UPPER, 32'h61626364, 0, 1);

    step("rot13_acc", 0, 1, STR_OP_ROT13, 32'h7A4E2E61, 0, 1);
    for (int i = 0; i < 6; i++) step("rot13_run", 0, 0, STR_OP_ROT13, 32'h0, 0, 1);

    // LEET held in DONE for 3 cycles with enable pulses, then released
    step("leet_acc", 0, 1, STR_OP_LEET, 32'h74736561, 0, 0);
    for (int i = 0; i < 4; i++) step("leet_busy", 0, 1, STR_OP_UPPER, 32'h61616161, 0, 0);
    for (int i = 0; i < 3; i++) step("leet_hold", 0, 1, STR_OP_UPPER, 32'h61616161, 0, 0);
    step("leet_release", 0, 0, STR_OP_LEET, 32'h0, 0, 1);
    step("leet_idle", 0, 0, STR_OP_LEET, 32'h0, 0, 1);

    // Undefined operator is ignored
    step("bad_op", 0, 1, 3'd5, 32'h61616161, 0, 1);
    step("bad_op_idle", 0, 0, 3'd7, 32'h61616161, 0, 1);

    // Flush at counter 2, then a fresh UPPER (flush in IDLE must not block it)
    step("flush_acc", 0, 1, STR_OP_LOWER, 32'h41414141, 0, 1);
    step("flush_c0", 0, 0, STR_OP_LOWER, 32'h0, 0, 1);
    step("flush_c1", 0, 0, STR_OP_LOWER, 32'h0, 0, 1);
    step("flush_c2", 0, 0, STR_OP_LOWER, 32'h0, 1, 1);
    step("after_flush_acc", 0, 1, STR_OP_UPPER, 32'h61616161, 1, 1);
    for (int i = 0; i < 6; i++) step("after_flush_run", 0, 0, STR_OP_UPPER, 32'h0, 0, 1);

    // Reset at counter 2, then a fresh UPPER
    step("rst_acc", 0, 1, STR_OP_ROT13, 32'h41414141, 0, 1);
    step("rst_c0", 0, 0, STR_OP_ROT13, 32'h0, 0, 1);
    step("rst_c1", 0, 0, STR_OP_ROT13, 32'h0, 0, 1);
    step("rst_c2", 1, 0, STR_OP_ROT13, 32'h0, 0, 1);
    step("after_rst_acc", 0, 1, STR_OP_UPPER, 32'h61616161, 0, 1);
    for (int i = 0; i < 6; i++) step("after_rst_run", 0, 0, STR_OP_UPPER, 32'h0, 0, 1);

    // Flush while DONE beats ex_ready
    step("flushdone_acc", 0, 1, STR_OP_LEET, 32'h6F69736F, 0, 0);
    for (int i = 0; i < 4; i++) step("flushdone_busy", 0, 0, STR_OP_LEET, 32'h0, 0, 0);
    step("flushdone_flush", 0, 0, STR_OP_LEET, 32'h0, 1, 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++)
      step("random", ($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1),
           STR_OP_WIDTH'($urandom_range(0, 7)), rand_operand(),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
